keypad_enc16: RTL and testbench

Scanning encoder for a 4x4 matrix keypad: it drives one keypad column low at a time and samples the four rows. It debounces the result and reports the pressed key as a 4-bit code, code = row*4 + col, on a valid/ready handshake. It is the input-side counterpart of the 4:16 display decoder. It turns a one-hot key position into the 4-bit value the processor consumes, with optional typematic auto-repeat.

---
 rtl/keypad_enc16.sv | 265 ++++++++++++++++++++++++++
 tb/tb_keypad_enc16.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_enc16.sv
// -----------------------------------------------------------------------------
// keypad_enc16 - scanning encoder for a 4x4 active-low matrix keypad.
//
// Drives one column low at a time, samples the four rows on the last clock of
// each column period, builds a 16-bit frame image and debounces the lowest
// pressed key code (code = row*4 + col). Debounced presses are offered to the
// consumer on a valid/ready handshake. A key that arrives while the previous
// one is still pending is dropped and raises a sticky overrun flag.
//
// Optional feature macro: KEYPAD_TYPEMATIC_EN
//   Defined   : a held key re-emits every REPEAT_FRAMES frames (auto-repeat).
//   Undefined : exactly one emit per debounced press.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   row_in     in   [3:0] keypad rows, active-low, pulled up externally
//   col_out    out  [3:0] column drive, exactly one bit low
//   key_code   out  [3:0] reported key code, stable while key_valid = 1
//   key_valid  out  key_code holds an unconsumed key
//   key_ready  in   consumer accepts; transfer when key_valid & key_ready
//   overrun    out  sticky: a key was dropped while another was pending
//   ovr_clr    in   clears overrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module keypad_enc16 #(
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun,
  input  logic       ovr_clr
);

  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_enc16: parameter out of legal range");
  end

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE);
`ifdef KEYPAD_TYPEMATIC_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_FRAMES);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD} state_t;

  // Synchronizer, scan counters and partial frame image (columns 0..2 only;
  // column 3 is taken live from the synchronizer at frame end).
  logic [3:0]  r_sync1, r_sync2;
  logic [15:0] r_div;
  logic [1:0]  r_col;
  logic [11:0] r_img;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_rcnt, w_rcnt_nxt;
`ifdef KEYPAD_TYPEMATIC_EN
  logic [15:0] r_rep, w_rep_nxt;
`endif

  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_overrun;

  logic        w_col_last, w_frame_end, w_none, w_emit, w_xfer;
  logic [15:0] w_frame;
  logic [3:0]  w_code, w_emit_code;

  assign w_col_last  = (r_div == DIV_LAST);
  assign w_frame_end = w_col_last && (r_col == 2'd3);
  assign col_out     = ~(4'b0001 << r_col);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_col <= '0;
      r_img <= '0;
    end else if (w_col_last) begin
      r_div <= '0;
      r_col <= r_col + 2'd1;
      for (int r = 0; r < 4; r++) begin
        case (r_col)
          2'd0:    r_img[r*3]     <= ~r_sync2[r];
          2'd1:    r_img[r*3 + 1] <= ~r_sync2[r];
          2'd2:    r_img[r*3 + 2] <= ~r_sync2[r];
          default: ;
        endcase
      end
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Full frame image and its lowest set bit (multiple keys -> lowest code).
  always_comb begin
    w_frame = '0;
    for (int r = 0; r < 4; r++) begin
      w_frame[r*4 +: 3] = r_img[r*3 +: 3];
      w_frame[r*4 + 3]  = ~r_sync2[r];
    end
  end

  assign w_none = (w_frame == 16'h0000);

  always_comb begin
    w_code = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (w_frame[i]) w_code = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
`ifdef KEYPAD_TYPEMATIC_EN
      r_rep   <= w_rep_nxt;
`endif
    end
  end

  // Debounce FSM, advanced only on the frame-end clock.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
`ifdef KEYPAD_TYPEMATIC_EN
    w_rep_nxt   = r_rep;
`endif
    w_emit      = 1'b0;
    w_emit_code = r_cand;
    if (w_frame_end) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_none) begin
            w_cand_nxt  = w_code;
            w_emit_code = w_code;
            if (DB_LAST == 4'd1) begin
              w_emit      = 1'b1;
              w_state_nxt = ST_HELD;
              w_rcnt_nxt  = '0;
`ifdef KEYPAD_TYPEMATIC_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_state_nxt = ST_CAND;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        ST_CAND: begin
          if (w_none) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_code == r_cand) begin
            if (r_cnt + 4'd1 == DB_LAST) begin
              w_emit      = 1'b1;
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = '0;
              w_rcnt_nxt  = '0;
`ifdef KEYPAD_TYPEMATIC_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = 4'd1;
          end
        end
        ST_HELD: begin
          if (w_none) begin
`ifdef KEYPAD_TYPEMATIC_EN
            w_rep_nxt = '0;
`endif
            if (r_rcnt + 4'd1 == DB_LAST) begin
              w_state_nxt = ST_IDLE;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + 4'd1;
            end
          end else begin
            // A key (even a different one) keeps the press alive; r_cand
            // keeps the emitted code so a repeat always re-sends it.
            w_rcnt_nxt = '0;
`ifdef KEYPAD_TYPEMATIC_EN
            if (w_code == r_cand && r_rcnt == 4'd0) begin
              if (r_rep + 16'd1 == REP_LAST) begin
                w_emit    = 1'b1;
                w_rep_nxt = '0;
              end else begin
                w_rep_nxt = r_rep + 16'd1;
              end
            end
`endif
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output handshake: an emit loads only when the slot is free or being
  // drained this cycle; otherwise it is dropped and flagged.
  assign w_xfer = r_key_valid & key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_emit && (!r_key_valid || w_xfer)) begin
        r_key_code  <= w_emit_code;
        r_key_valid <= 1'b1;
      end else if (w_xfer) begin
        r_key_valid <= 1'b0;
      end
      if (w_emit && r_key_valid && !w_xfer) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_enc16.sv
// -----------------------------------------------------------------------------
// tb_keypad_enc16 - self-checking bench for keypad_enc16 (SCAN_DIV=4,
// DEBOUNCE=3, REPEAT_FRAMES=8). A keypad model turns a 16-bit "pressed" vector
// into row levels from col_out; a frame-level reference model predicts
// key_valid, key_code, overrun and col_out every clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_enc16;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE      = 3;
  localparam int REPEAT_FRAMES = 8;
  localparam int FRAME         = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;
  logic       ovr_clr;
  logic [15:0] pressed;

  keypad_enc16 #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  // Keypad: row r is pulled low when any pressed key in row r sits on the
  // column currently driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end
  end

  int checks;
  int errors;
  int cyc;
  int pulses;
  logic [3:0] last_pulse_code;
  logic       prev_valid;

  // Reference state
  logic       m_valid;
  logic       m_ovr;
  logic [3:0] m_code;
  bit         mf_held;
  int         mf_last, mf_run, mf_empty, mf_rep;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lowest_key(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0; cyc = 0;
    mf_held = 1'b0; mf_last = -1; mf_run = 0; mf_empty = 0; mf_rep = 0;
    prev_valid = 1'b0;
  endtask

  // One frame of debounce behaviour: run length of identical keys while not
  // held, run length of empty frames while held.
  task automatic frame_step(output bit emit, output int code_out);
    int k;
    k = lowest_key(pressed);
    emit = 1'b0;
    code_out = 0;
    if (!mf_held) begin
      if (k < 0) begin
        mf_run = 0;
      end else begin
        if (mf_run > 0 && k == mf_last) mf_run++;
        else begin mf_run = 1; mf_last = k; end
        if (mf_run == DEBOUNCE) begin
          emit = 1'b1; code_out = k;
          mf_held = 1'b1; mf_empty = 0; mf_rep = 0;
        end
      end
    end else begin
      if (k < 0) begin
        mf_empty++;
        mf_rep = 0;
        if (mf_empty == DEBOUNCE) begin mf_held = 1'b0; mf_run = 0; end
      end else begin
`ifdef KEYPAD_TYPEMATIC_EN
        if (k == mf_last && mf_empty == 0) begin
          mf_rep++;
          if (mf_rep == REPEAT_FRAMES) begin
            emit = 1'b1; code_out = mf_last; mf_rep = 0;
          end
        end
`endif
        mf_empty = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit emit, xfer, drop;
    int ec;
    emit = 1'b0; ec = 0; drop = 1'b0;
    if (cyc % FRAME == FRAME - 1) frame_step(emit, ec);
    xfer = m_valid && key_ready;
    if (emit) begin
      if (!m_valid || xfer) begin m_code = 4'(ec); m_valid = 1'b1; end
      else drop = 1'b1;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    cyc++;
  endtask

  task automatic cycle(input logic rdy, input logic clr);
    logic [3:0] one;
    one = 4'b0001;
    key_ready = rdy;
    ovr_clr   = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    check("key_code", key_code, m_code);
    check("overrun", {3'b0, overrun}, {3'b0, m_ovr});
    check("col_out", col_out, ~(one << ((cyc / SCAN_DIV) % 4)));
    if (key_valid && !prev_valid) begin
      pulses++;
      last_pulse_code = key_code;
    end
    prev_valid = key_valid;
  endtask

  // mode 0: ready low, 1: ready high, 2: random ready and ovr_clr
  task automatic run_frames(input int n, input logic [15:0] p, input int mode);
    logic rdy, clr;
    pressed = p;
    repeat (n * FRAME) begin
      if (mode == 2) begin
        rdy = ($urandom_range(0, 2) != 0);
        clr = ($urandom_range(0, 9) == 0);
      end else begin
        rdy = (mode == 1);
        clr = 1'b0;
      end
      cycle(rdy, clr);
    end
  endtask

  task automatic do_reset();
    pressed = '0; key_ready = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", {3'b0, key_valid}, 4'h0);
    check("rst_overrun", {3'b0, overrun}, 4'h0);
    check("rst_key_code", key_code, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] p;
    int sel;
    checks = 0; errors = 0; pulses = 0; last_pulse_code = 4'h0;
    rst_n = 1'b0; pressed = '0; key_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    do_reset();

    // Idle frame: column stepping is checked every clock.
    run_frames(1, 16'h0000, 1);

    // Single press: row 2 col 1 held 6 frames.
    pulses = 0;
    run_frames(6, 16'h0200, 1);
    run_frames(4, 16'h0000, 1);
    check("single_pulses", 4'(pulses), 4'd1);
    check("single_code", last_pulse_code, 4'h9);

    // Bounce: 2 frames, gap, 3 frames of key 3.
    pulses = 0;
    run_frames(2, 16'h0008, 1);
    run_frames(1, 16'h0000, 1);
    check("bounce_early", 4'(pulses), 4'd0);
    run_frames(3, 16'h0008, 1);
    run_frames(4, 16'h0000, 1);
    check("bounce_pulses", 4'(pulses), 4'd1);
    check("bounce_code", last_pulse_code, 4'h3);

    // Multi-key: 5 and E together resolve to 5.
    pulses = 0;
    run_frames(4, 16'h4020, 1);
    run_frames(4, 16'h0000, 1);
    check("multi_pulses", 4'(pulses), 4'd1);
    check("multi_code", last_pulse_code, 4'h5);

    // Backpressure: 3 pending, 7 dropped.
    run_frames(3, 16'h0008, 0);
    run_frames(3, 16'h0000, 0);
    run_frames(3, 16'h0080, 0);
    check("bp_valid", {3'b0, key_valid}, 4'h1);
    check("bp_code", key_code, 4'h3);
    check("bp_overrun", {3'b0, overrun}, 4'h1);
    cycle(1'b1, 1'b0);
    check("bp_drain", {3'b0, key_valid}, 4'h0);
    cycle(1'b0, 1'b1);
    check("bp_ovr_clr", {3'b0, overrun}, 4'h0);
    pressed = '0;
    repeat (FRAME - 2) cycle(1'b1, 1'b0);
    run_frames(3, 16'h0000, 1);

    // Typematic: key A held 30 frames.
    pulses = 0;
    run_frames(30, 16'h0400, 1);
    run_frames(4, 16'h0000, 1);
`ifdef KEYPAD_TYPEMATIC_EN
    check("typematic_pulses", 4'(pulses), 4'd4);
`else
    check("typematic_pulses", 4'(pulses), 4'd1);
`endif
    check("typematic_code", last_pulse_code, 4'hA);

    // Randomized segments with random handshake, one mid-frame reset.
    for (int seg = 0; seg < 40; seg++) begin
      sel = $urandom_range(0, 2);
      p = '0;
      if (sel >= 1) p[$urandom_range(0, 15)] = 1'b1;
      if (sel == 2) p[$urandom_range(0, 15)] = 1'b1;
      run_frames($urandom_range(1, 5), p, 2);
      if (seg == 20) begin
        pressed = 16'h0100;
        repeat ($urandom_range(1, 13)) cycle(1'b0, 1'b0);
        do_reset();
      end
    end
    run_frames(4, 16'h0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
